// File: rtl/mem_stage_pkg.sv
// Shared constants, funct3 encodings, FSM state and EX/MEM payload for the memory stage.
package mem_stage_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned NSTRB  = XLEN / 8;

  // Load encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  // Store encodings
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  // EX/MEM pipeline register contents; control bits are stored already gated by valid.
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] store_data;
    logic [4:0]      rd;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic [2:0]      funct3;
  } ex_mem_t;

endpackage

// File: rtl/mem_stage_if.sv
// Execute-side inputs, data-memory bus, hazard and write-back signals of the memory stage.
interface mem_stage_if;
  import mem_stage_pkg::*;

  logic              ex_valid;
  logic [XLEN-1:0]   ex_alu_result;
  logic [XLEN-1:0]   ex_store_data;
  logic [4:0]        ex_rd;
  logic              ex_reg_write;
  logic              ex_mem_read;
  logic              ex_mem_write;
  logic [2:0]        ex_funct3;

  logic [XLEN-1:0]   ex_mem_alu_result;
  logic [4:0]        ex_mem_rd;
  logic              ex_mem_reg_write;

  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [XLEN-1:0]   dmem_wdata;
  logic [NSTRB-1:0]  dmem_wstrb;
  logic              dmem_ready;
  logic [XLEN-1:0]   dmem_rdata;

  logic              mem_stall;
  logic              mem_misalign;
  logic              wb_valid;
  logic [4:0]        wb_rd;
  logic              wb_reg_write;
  logic [XLEN-1:0]   write_data;

  // The memory stage itself: masters the data-memory bus and drives WB/forwarding.
  modport master (
    input  ex_valid, ex_alu_result, ex_store_data, ex_rd, ex_reg_write,
           ex_mem_read, ex_mem_write, ex_funct3, dmem_ready, dmem_rdata,
    output ex_mem_alu_result, ex_mem_rd, ex_mem_reg_write, dmem_req, dmem_we,
           dmem_addr, dmem_wdata, dmem_wstrb, mem_stall, mem_misalign,
           wb_valid, wb_rd, wb_reg_write, write_data
  );

  // Surroundings: execute stage, data memory, hazard unit and register file.
  modport slave (
    output ex_valid, ex_alu_result, ex_store_data, ex_rd, ex_reg_write,
           ex_mem_read, ex_mem_write, ex_funct3, dmem_ready, dmem_rdata,
    input  ex_mem_alu_result, ex_mem_rd, ex_mem_reg_write, dmem_req, dmem_we,
           dmem_addr, dmem_wdata, dmem_wstrb, mem_stall, mem_misalign,
           wb_valid, wb_rd, wb_reg_write, write_data
  );

endinterface

// File: rtl/mem_stage_load_store_align.sv
// Combinational store lane steering, load extraction and misalignment detection.
module mem_stage_load_store_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]       i_funct3,
  input  logic [1:0]       i_addr_lo,
  input  logic             i_mem_read,
  input  logic             i_mem_write,
  input  logic [XLEN-1:0]  i_store_data,
  input  logic [XLEN-1:0]  i_rdata,
  output logic [XLEN-1:0]  o_wdata,
  output logic [NSTRB-1:0] o_wstrb,
  output logic [XLEN-1:0]  o_load_data,
  output logic             o_misalign
);

  logic [XLEN-1:0] w_shifted;

  assign w_shifted = i_rdata >> {i_addr_lo, 3'b000};

  // Replicate store data across lanes and enable only the addressed bytes
  always_comb begin
    o_wdata = i_store_data;
    o_wstrb = '0;
    if (i_mem_write) begin
      case (i_funct3)
        F3_SB: begin
          o_wdata = {4{i_store_data[7:0]}};
          o_wstrb = NSTRB'(1) << i_addr_lo;
        end
        F3_SH: begin
          o_wdata = {2{i_store_data[15:0]}};
          o_wstrb = NSTRB'(3) << {i_addr_lo[1], 1'b0};
        end
        F3_SW:   o_wstrb = '1;
        default: o_wstrb = '0;
      endcase
    end
  end

  // Pick the addressed byte/half from the read word and extend it
  always_comb begin
    case (i_funct3)
      F3_LB:   o_load_data = {{(XLEN-8){w_shifted[7]}}, w_shifted[7:0]};
      F3_LBU:  o_load_data = XLEN'(w_shifted[7:0]);
      F3_LH:   o_load_data = {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
      F3_LHU:  o_load_data = XLEN'(w_shifted[15:0]);
      F3_LW:   o_load_data = w_shifted;
      default: o_load_data = w_shifted;
    endcase
  end

  // Halfwords need an even address, words a multiple of four
  always_comb begin
    o_misalign = 1'b0;
    if (i_mem_write) begin
      if (i_funct3 == F3_SH)      o_misalign = i_addr_lo[0];
      else if (i_funct3 == F3_SW) o_misalign = |i_addr_lo;
    end else if (i_mem_read) begin
      if (i_funct3 == F3_LH || i_funct3 == F3_LHU) o_misalign = i_addr_lo[0];
      else if (i_funct3 == F3_LW)                  o_misalign = |i_addr_lo;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: EX/MEM register, data-memory handshake, MEM/WB register.
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  mem_stage_if.master bus
);
  import mem_stage_pkg::*;

  ex_mem_t          w_ex_in;
  ex_mem_t          r_ex_mem;
  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_access;
  logic             w_misalign_raw;
  logic             w_misalign;
  logic             w_m_mem;
  logic             w_req;
  logic             w_stall;
  logic [XLEN-1:0]  w_wdata;
  logic [XLEN-1:0]  w_load_data;
  logic [NSTRB-1:0] w_wstrb;
  logic             r_wb_valid;
  logic             r_wb_reg_write;
  logic [4:0]       r_wb_rd;
  logic [XLEN-1:0]  r_write_data;

  // Incoming instruction; an invalid slot becomes a bubble with all control cleared
  always_comb begin
    w_ex_in            = '0;
    w_ex_in.valid      = bus.ex_valid;
    w_ex_in.alu_result = bus.ex_alu_result;
    w_ex_in.store_data = bus.ex_store_data;
    w_ex_in.rd         = bus.ex_rd;
    w_ex_in.funct3     = bus.ex_funct3;
    w_ex_in.reg_write  = bus.ex_valid & bus.ex_reg_write;
    w_ex_in.mem_read   = bus.ex_valid & bus.ex_mem_read;
    w_ex_in.mem_write  = bus.ex_valid & bus.ex_mem_write;
  end

  // EX/MEM register, frozen while an access is outstanding
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_ex_mem <= '0;
    else if (!w_stall) r_ex_mem <= w_ex_in;
  end

  mem_stage_load_store_align u_align (
    .i_funct3     (r_ex_mem.funct3),
    .i_addr_lo    (r_ex_mem.alu_result[1:0]),
    .i_mem_read   (r_ex_mem.mem_read),
    .i_mem_write  (r_ex_mem.mem_write),
    .i_store_data (r_ex_mem.store_data),
    .i_rdata      (bus.dmem_rdata),
    .o_wdata      (w_wdata),
    .o_wstrb      (w_wstrb),
    .o_load_data  (w_load_data),
    .o_misalign   (w_misalign_raw)
  );

  assign w_access   = r_ex_mem.valid & (r_ex_mem.mem_read | r_ex_mem.mem_write);
  assign w_misalign = w_access & w_misalign_raw;
  assign w_m_mem    = w_access & ~w_misalign_raw;

  // Handshake state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Enter WAIT when the memory does not accept in the request cycle
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_m_mem && !bus.dmem_ready) w_state_nxt = S_WAIT;
      S_WAIT:  if (bus.dmem_ready)             w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Request and stall; the request is held through WAIT until ready
  always_comb begin
    w_req   = 1'b0;
    w_stall = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_req   = w_m_mem;
        w_stall = w_m_mem & ~bus.dmem_ready;
      end
      S_WAIT: begin
        w_req   = 1'b1;
        w_stall = ~bus.dmem_ready;
      end
      default: begin
        w_req   = 1'b0;
        w_stall = 1'b0;
      end
    endcase
  end

  // MEM/WB register; stalled cycles write a bubble and keep the last result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wb_valid     <= 1'b0;
      r_wb_reg_write <= 1'b0;
      r_wb_rd        <= '0;
      r_write_data   <= '0;
    end else if (w_stall) begin
      r_wb_valid     <= 1'b0;
      r_wb_reg_write <= 1'b0;
    end else begin
      r_wb_valid     <= r_ex_mem.valid;
      r_wb_rd        <= r_ex_mem.rd;
      r_wb_reg_write <= r_ex_mem.reg_write & ~w_misalign & (r_ex_mem.rd != 5'd0);
      if (r_ex_mem.valid)
        r_write_data <= (r_ex_mem.mem_read && !w_misalign) ? w_load_data
                                                            : r_ex_mem.alu_result;
    end
  end

  assign bus.ex_mem_alu_result = r_ex_mem.alu_result;
  assign bus.ex_mem_rd         = r_ex_mem.rd;
  assign bus.ex_mem_reg_write  = r_ex_mem.reg_write;
  assign bus.dmem_req          = w_req;
  assign bus.dmem_we           = w_req & r_ex_mem.mem_write;
  assign bus.dmem_addr         = {r_ex_mem.alu_result[ADDR_W-1:2], 2'b00};
  assign bus.dmem_wdata        = w_wdata;
  assign bus.dmem_wstrb        = w_req ? w_wstrb : '0;
  assign bus.mem_stall         = w_stall;
  assign bus.mem_misalign      = w_misalign;
  assign bus.wb_valid          = r_wb_valid;
  assign bus.wb_rd             = r_wb_rd;
  assign bus.wb_reg_write      = r_wb_reg_write;
  assign bus.write_data        = r_write_data;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with an instruction-level reference model.
module tb_mem_stage;

  localparam logic [2:0] LB = 3'd0, LH = 3'd1, LW = 3'd2, LBU = 3'd4, LHU = 3'd5;
  localparam logic [2:0] SB = 3'd0, SH = 3'd1, SW = 3'd2;

  typedef struct {
    logic        v;
    logic [2:0]  f3;
    logic        mr, mw, rw;
    logic [4:0]  rd;
    logic [31:0] alu, sd;
  } ins_t;

  typedef struct {
    ins_t        ins;
    int          waits;
    logic [31:0] rdata;
    logic [31:0] exp_wd;
  } vec_t;

  logic clk;
  logic rst;
  mem_stage_if bus ();

  mem_stage u_dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_err = 0;

  // Model state: the instruction sitting in MEM and the last WB result
  ins_t        mm;
  logic        wv, wrw;
  logic [4:0]  wrd;
  logic [31:0] wd;
  logic        e_req;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish (got running, want finished)");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic ins_t mk(input logic v, input logic [2:0] f3, input logic mr,
                              input logic mw, input logic rw, input logic [4:0] rd,
                              input logic [31:0] alu, input logic [31:0] sd);
    ins_t x;
    x.v = v; x.f3 = f3; x.mr = mr; x.mw = mw; x.rw = rw; x.rd = rd; x.alu = alu; x.sd = sd;
    return x;
  endfunction

  // Access size in bytes
  function automatic int unsigned sz(input logic [2:0] f3);
    case (f3)
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 1;
    endcase
  endfunction

  function automatic bit mis(input ins_t x);
    if (!(x.mr || x.mw)) return 1'b0;
    return ((x.alu % 4) % sz(x.f3)) != 0;
  endfunction

  function automatic bit needs_mem(input ins_t x);
    return x.v && (x.mr || x.mw) && !mis(x);
  endfunction

  function automatic logic [31:0] strb(input ins_t x);
    if (!x.mw || x.f3 > 3'd2) return 32'd0;
    return ((32'd1 << sz(x.f3)) - 32'd1) << (x.alu % 4);
  endfunction

  function automatic logic [31:0] wdat(input ins_t x);
    if (x.f3 == SB) return (x.sd % 256) * 32'h0101_0101;
    if (x.f3 == SH) return (x.sd % 65536) * 32'h0001_0001;
    return x.sd;
  endfunction

  function automatic logic [31:0] ld(input ins_t x, input logic [31:0] rdata);
    logic [31:0] w;
    logic [31:0] b;
    logic [31:0] h;
    w = rdata >> (8 * (x.alu % 4));
    b = w % 256;
    h = w % 65536;
    case (x.f3)
      LB:      return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      LBU:     return b;
      LH:      return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      LHU:     return h;
      default: return w;
    endcase
  endfunction

  // Reference model: advance one instruction per edge unless the access is pending
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mm = mk(0, 0, 0, 0, 0, 0, 0, 0);
      wv = 0; wrw = 0; wrd = 0; wd = 0;
    end else if (needs_mem(mm) && !bus.dmem_ready) begin
      wv = 0; wrw = 0;
    end else begin
      if (mm.v) begin
        wv  = 1;
        wrd = mm.rd;
        wrw = mm.rw && !mis(mm) && (mm.rd != 0);
        wd  = (mm.mr && !mis(mm)) ? ld(mm, bus.dmem_rdata) : mm.alu;
      end else begin
        wv = 0; wrw = 0;
      end
      mm.v   = bus.ex_valid;
      mm.f3  = bus.ex_funct3;
      mm.alu = bus.ex_alu_result;
      mm.sd  = bus.ex_store_data;
      mm.rd  = bus.ex_rd;
      mm.rw  = bus.ex_valid && bus.ex_reg_write;
      mm.mr  = bus.ex_valid && bus.ex_mem_read;
      mm.mw  = bus.ex_valid && bus.ex_mem_write;
    end
  end

  // Compare every cycle, after the inputs driven at the falling edge have settled
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      e_req = needs_mem(mm);
      chk("dmem_req", 32'(bus.dmem_req), 32'(e_req));
      chk("mem_stall", 32'(bus.mem_stall), 32'(e_req && !bus.dmem_ready));
      chk("mem_misalign", 32'(bus.mem_misalign), 32'(mm.v && (mm.mr || mm.mw) && mis(mm)));
      chk("ex_mem_alu_result", bus.ex_mem_alu_result, mm.alu);
      chk("ex_mem_rd", 32'(bus.ex_mem_rd), 32'(mm.rd));
      chk("ex_mem_reg_write", 32'(bus.ex_mem_reg_write), 32'(mm.v && mm.rw));
      chk("wb_valid", 32'(bus.wb_valid), 32'(wv));
      chk("wb_reg_write", 32'(bus.wb_reg_write), 32'(wrw));
      chk("write_data", bus.write_data, wd);
      if (wv) chk("wb_rd", 32'(bus.wb_rd), 32'(wrd));
      if (e_req) begin
        chk("dmem_we", 32'(bus.dmem_we), 32'(mm.mw));
        chk("dmem_addr", bus.dmem_addr, mm.alu - (mm.alu % 4));
        chk("dmem_wstrb", 32'(bus.dmem_wstrb), strb(mm));
        if (mm.mw) chk("dmem_wdata", bus.dmem_wdata, wdat(mm));
      end
    end
  end

  task automatic drive_ex(input ins_t x);
    bus.ex_valid      = x.v;
    bus.ex_funct3     = x.f3;
    bus.ex_mem_read   = x.mr;
    bus.ex_mem_write  = x.mw;
    bus.ex_reg_write  = x.rw;
    bus.ex_rd         = x.rd;
    bus.ex_alu_result = x.alu;
    bus.ex_store_data = x.sd;
  endtask

  task automatic set_mem(input logic rdy, input logic [31:0] rdata);
    bus.dmem_ready = rdy;
    bus.dmem_rdata = rdata;
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // One instruction followed by bubbles, memory answering after 'waits' wait states
  task automatic issue(input ins_t x, input int waits, input logic [31:0] rdata);
    cyc(); drive_ex(x); set_mem(0, 0);
    for (int i = 0; i <= waits; i++) begin
      cyc(); drive_ex(mk(0, 0, 0, 0, 0, 0, 0, 0)); set_mem(i == waits, rdata);
    end
  endtask

  ins_t bub;
  vec_t tbl[9];

  initial begin
    bub = mk(0, 0, 0, 0, 0, 0, 0, 0);
    tbl[0] = '{mk(1, SB,  0, 1, 0, 0,  32'h0F3, 32'h0000_00AB), 1, 32'h0,         32'h0000_00F3};
    tbl[1] = '{mk(1, LH,  1, 0, 1, 10, 32'h106, 32'h0),         0, 32'h9ABC_0000, 32'hFFFF_9ABC};
    tbl[2] = '{mk(1, LBU, 1, 0, 1, 11, 32'h101, 32'h0),         3, 32'h0000_F000, 32'h0000_00F0};
    tbl[3] = '{mk(1, SH,  0, 1, 0, 0,  32'h103, 32'h1111),      0, 32'h0,         32'h0000_0103};
    tbl[4] = '{mk(1, SW,  0, 1, 0, 0,  32'h204, 32'h0123_4567), 2, 32'h0,         32'h0000_0204};
    tbl[5] = '{mk(1, LW,  1, 0, 1, 13, 32'h208, 32'h0),         0, 32'hCAFE_F00D, 32'hCAFE_F00D};
    tbl[6] = '{mk(1, LB,  1, 0, 1, 14, 32'h000, 32'h0),         1, 32'h0000_007F, 32'h0000_007F};
    tbl[7] = '{mk(1, 3'd0, 0, 0, 1, 12, 32'h077, 32'h0),        0, 32'h0,         32'h0000_0077};
    tbl[8] = '{mk(0, LW,  1, 0, 1, 15, 32'h400, 32'h0),         0, 32'hFFFF_FFFF, 32'h0000_0077};

    rst = 1'b1;
    drive_ex(bub);
    set_mem(0, 0);
    #1;
    chk("reset dmem_req", 32'(bus.dmem_req), 32'd0);
    chk("reset mem_stall", 32'(bus.mem_stall), 32'd0);
    chk("reset wb_valid", 32'(bus.wb_valid), 32'd0);
    chk("reset write_data", bus.write_data, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // SW to 0x100, zero-wait memory
    cyc(); drive_ex(mk(1, SW, 0, 1, 0, 0, 32'h100, 32'hDEAD_BEEF)); set_mem(0, 0);
    cyc(); drive_ex(bub); set_mem(1, 0); #3;
    chk("sw req", 32'(bus.dmem_req), 32'd1);
    chk("sw we", 32'(bus.dmem_we), 32'd1);
    chk("sw wstrb", 32'(bus.dmem_wstrb), 32'hF);
    chk("sw addr", bus.dmem_addr, 32'h100);
    chk("sw wdata", bus.dmem_wdata, 32'hDEAD_BEEF);
    chk("sw stall", 32'(bus.mem_stall), 32'd0);

    // ALU op to x5 then LB from 0x103 with two wait states
    cyc(); drive_ex(mk(1, 3'd0, 0, 0, 1, 5, 32'h42, 32'h0)); set_mem(0, 0);
    cyc(); drive_ex(mk(1, LB, 1, 0, 1, 7, 32'h103, 32'h0)); set_mem(0, 0); #3;
    chk("fwd alu_result", bus.ex_mem_alu_result, 32'h42);
    chk("fwd rd", 32'(bus.ex_mem_rd), 32'd5);
    chk("fwd reg_write", 32'(bus.ex_mem_reg_write), 32'd1);
    cyc(); drive_ex(bub); set_mem(0, 32'h80FF_0000); #3;
    chk("alu write_data", bus.write_data, 32'h42);
    chk("lb stall w1", 32'(bus.mem_stall), 32'd1);
    chk("lb addr", bus.dmem_addr, 32'h100);
    cyc(); set_mem(0, 32'h80FF_0000); #3;
    chk("lb stall w2", 32'(bus.mem_stall), 32'd1);
    chk("lb bubble", 32'(bus.wb_valid), 32'd0);
    cyc(); set_mem(1, 32'h80FF_0000); #3;
    chk("lb stall done", 32'(bus.mem_stall), 32'd0);
    cyc(); set_mem(0, 0); #3;
    chk("lb write_data", bus.write_data, 32'hFFFF_FF80);
    chk("lb wb_valid", 32'(bus.wb_valid), 32'd1);

    // LHU from 0x102 then SH to 0x102
    cyc(); drive_ex(mk(1, LHU, 1, 0, 1, 9, 32'h102, 32'h0)); set_mem(0, 0);
    cyc(); drive_ex(mk(1, SH, 0, 1, 0, 0, 32'h102, 32'h0000_5678)); set_mem(1, 32'h8001_1234); #3;
    chk("lhu wstrb", 32'(bus.dmem_wstrb), 32'd0);
    cyc(); drive_ex(bub); set_mem(1, 0); #3;
    chk("lhu write_data", bus.write_data, 32'h0000_8001);
    chk("sh wdata", bus.dmem_wdata, 32'h5678_5678);
    chk("sh wstrb", 32'(bus.dmem_wstrb), 32'hC);

    // Misaligned LW to 0x101
    cyc(); drive_ex(mk(1, LW, 1, 0, 1, 3, 32'h101, 32'h0)); set_mem(0, 0);
    cyc(); drive_ex(bub); set_mem(0, 0); #3;
    chk("mis req", 32'(bus.dmem_req), 32'd0);
    chk("mis pulse", 32'(bus.mem_misalign), 32'd1);
    cyc(); #3;
    chk("mis pulse end", 32'(bus.mem_misalign), 32'd0);
    chk("mis wb_valid", 32'(bus.wb_valid), 32'd1);
    chk("mis wb_reg_write", 32'(bus.wb_reg_write), 32'd0);

    // Load to x0 still accesses memory but does not write
    issue(mk(1, LW, 1, 0, 1, 0, 32'h200, 32'h0), 1, 32'h1111_1111);
    cyc(); set_mem(0, 0); #3;
    chk("x0 wb_reg_write", 32'(bus.wb_reg_write), 32'd0);
    chk("x0 write_data", bus.write_data, 32'h1111_1111);

    // Table of further access patterns
    foreach (tbl[k]) begin
      issue(tbl[k].ins, tbl[k].waits, tbl[k].rdata);
      cyc(); set_mem(0, 0); #3;
      chk($sformatf("tbl%0d write_data", k), bus.write_data, tbl[k].exp_wd);
    end

    // Reset while waiting on memory
    cyc(); drive_ex(mk(1, LW, 1, 0, 1, 4, 32'h300, 32'h0)); set_mem(0, 0);
    cyc(); drive_ex(bub); set_mem(0, 0); #3;
    chk("rst pre req", 32'(bus.dmem_req), 32'd1);
    cyc(); #3;
    chk("rst wait req", 32'(bus.dmem_req), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("async req", 32'(bus.dmem_req), 32'd0);
    chk("async stall", 32'(bus.mem_stall), 32'd0);
    chk("async wb_valid", 32'(bus.wb_valid), 32'd0);
    chk("async write_data", bus.write_data, 32'd0);
    cyc(); cyc(); rst = 1'b0; #3;
    chk("idle after reset req", 32'(bus.dmem_req), 32'd0);
    issue(mk(1, LW, 1, 0, 1, 4, 32'h300, 32'h0), 1, 32'h55AA_55AA);
    cyc(); set_mem(0, 0); #3;
    chk("post-reset load", bus.write_data, 32'h55AA_55AA);

    cyc(); cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage directly downstream of the execute stage.
- Contains the EX/MEM pipeline register, a data-memory request/ready handshake FSM, store byte-lane steering, load alignment/sign-extension, and the MEM/WB pipeline register.
- Sources the EX/MEM ALU result and the WB write data that feed the execute stage's forwarding muxes.
- Raises a stall to the hazard unit while a data access is outstanding.

Parameters:
XLEN, 32, datapath width (only 32 supported)
ADDR_W, 32, data-memory byte-address width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
ex_valid  in  1  EX stage holds a valid instruction
ex_alu_result  in  XLEN  ALU result (address for loads/stores)
ex_store_data  in  XLEN  forwarded rs2 value
ex_rd  in  5  destination register
ex_reg_write  in  1  instruction writes rd
ex_mem_read  in  1  load
ex_mem_write  in  1  store
ex_funct3  in  3  access size/sign
ex_mem_alu_result  out  XLEN  EX/MEM ALU result, for forwarding
ex_mem_rd  out  5  EX/MEM rd, for the forwarding unit
ex_mem_reg_write  out  1  EX/MEM reg_write gated by valid
dmem_req  out  1  access request
dmem_we  out  1  1 = write
dmem_addr  out  ADDR_W  word-aligned address (bits [1:0] = 0)
dmem_wdata  out  XLEN  lane-replicated store data
dmem_wstrb  out  4  byte enables
dmem_ready  in  1  access accepted/completed this cycle
dmem_rdata  in  XLEN  read word, valid when dmem_ready
mem_stall  out  1  hold EX and earlier stages
mem_misalign  out  1  one-cycle pulse on misaligned access
wb_valid  out  1  MEM/WB valid
wb_rd  out  5  MEM/WB rd
wb_reg_write  out  1  MEM/WB write enable
write_data  out  XLEN  WB result (load data or ALU result)

Behaviour:
- Reset (async, rst high): all registers clear, FSM = IDLE, and every output is 0. This includes dmem_req, mem_stall, wb_valid and write_data.
- EX/MEM register:
  - Loads the ex_* inputs on each rising edge when mem_stall = 0.
  - Holds its contents when mem_stall = 1.
  - ex_valid = 0 loads a bubble: all control bits are cleared.
- Memory operation: m_mem = valid & (mem_read | mem_write) & ~misaligned.
- Misaligned access:
  - LH/LHU/SH with addr[0] = 1 is misaligned.
  - LW/SW with addr[1:0] != 0 is misaligned.
  - No bus access is issued. reg_write is suppressed. mem_misalign pulses for 1 cycle. The instruction passes to WB as a no-op with wb_valid = 1.
- FSM states: IDLE and WAIT.
  - IDLE: if m_mem, assert dmem_req.
    - If dmem_ready is also asserted in the same cycle, the access completes, there is no stall, and the FSM stays in IDLE.
    - Otherwise mem_stall = 1 and next state = WAIT.
  - WAIT: dmem_req is held high, and dmem_addr, dmem_we, dmem_wdata and dmem_wstrb are held stable. mem_stall = 1 until dmem_ready; on dmem_ready, mem_stall = 0 and next state = IDLE.
  - mem_stall = m_mem & ~dmem_ready (combinational).
  - Latency: 0 stall cycles with a zero-wait memory, N stall cycles for N wait states.
- Store steering:
  - SB: wdata = {4{byte}}, wstrb = 0001 << addr[1:0].
  - SH: wdata = {2{half}}, wstrb = 0011 << {addr[1],1'b0}.
  - SW: wstrb = 1111.
  - Loads: wstrb = 0000.
- Load extraction, from dmem_rdata shifted by addr[1:0]:
  - LB sign-extends, LBU zero-extends.
  - LH sign-extends, LHU zero-extends.
  - LW passes the word through.
  - Unsupported funct3 values return zero-extended word data.
- MEM/WB register:
  - Updates each edge with the completed instruction. write_data = load result if mem_read, else the ALU result.
  - While mem_stall = 1, a bubble is written: wb_valid = 0, wb_reg_write = 0, and write_data holds its previous value.
- A load to rd = x0 still performs the access, but wb_reg_write = 0.
- Reset asserted mid-access: dmem_req drops asynchronously and the FSM returns to IDLE. The memory side must tolerate an abandoned request.

Decomposition:
- Shared package holds:
  - funct3 load/store encodings (LB/LH/LW/LBU/LHU/SB/SH/SW)
  - FSM state encoding
  - XLEN constant
- One natural sub-module: load_store_align. It is combinational: store wdata/wstrb, load extraction, and misalign detect.

Test Plan:
- SW 0xDEADBEEF to 0x100 with zero-wait memory -> dmem_req=1, we=1, wstrb=1111, addr=0x100 in the same cycle; mem_stall=0 throughout.
- LB from 0x103 with rdata=0x80FF_0000, 2 wait states -> mem_stall high for exactly 2 cycles; then write_data=0xFFFFFF80 and wb_valid=1; bubbles (wb_valid=0) appear during the stall.
- LHU from 0x102 with rdata=0x8001_1234 -> write_data=0x00008001; SH 0x00005678 to 0x102 -> wdata=0x56785678, wstrb=1100.
- LW to 0x101 -> dmem_req stays 0, mem_misalign pulses 1 cycle, wb_reg_write=0.
- Back-to-back ALU op (rd=x5, result 0x42) then load -> ex_mem_alu_result=0x42 and ex_mem_rd=5 in cycle 1; write_data=0x42 in cycle 2.
- rst asserted while in WAIT -> dmem_req, mem_stall and wb_valid go 0 immediately (asynchronously); the FSM is in IDLE on release.
